// File: rtl/fpu_mul_pkg.sv
// Shared constants and stage records for the single-precision multiplier datapath.
package fpu_mul_pkg;

  localparam int D_WIDTH = 32;
  localparam int M_WIDTH = 23;
  localparam int E_WIDTH = 8;
  localparam int P_WIDTH = 2 * (M_WIDTH + 1);
  localparam int X_WIDTH = E_WIDTH + 2;

  localparam logic [D_WIDTH-1:0] QNAN = 32'h7FC00000;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  // Normalized but unrounded beat held between the two pipeline stages.
  typedef struct packed {
    logic               sign;
    logic [X_WIDTH-1:0] exp;
    logic [M_WIDTH-1:0] mant;
    logic               rnd;
    logic               sticky;
    logic               nan;
    logic               inf;
    logic               zero;
  } s1_t;

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even on a stored mantissa; shared with the adder path.
module rne_rounder #(
  parameter int M_WIDTH = 23
) (
  input  logic [M_WIDTH-1:0] mant,
  input  logic               rnd,
  input  logic               sticky,
  output logic [M_WIDTH-1:0] mant_r,
  output logic               carry,
  output logic               inexact
);

  logic inc;

  // Exact ties round up only when the kept LSB is odd.
  assign inc = rnd & (sticky | mant[0]);
  // An all-ones mantissa wraps to zero with carry, which is the required result.
  assign {carry, mant_r} = {1'b0, mant} + {{M_WIDTH{1'b0}}, inc};
  assign inexact = rnd | sticky;

endmodule

// File: rtl/fp32_mul_round_pack.sv
// Two-stage normalize / round / pack for the binary32 multiplier, valid/ready on both sides.
module fp32_mul_round_pack
  import fpu_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_WIDTH-1:0] prod_in,
  input  logic [X_WIDTH-1:0] exp_in,
  input  logic               sign_in,
  input  logic               nan_in,
  input  logic               inf_in,
  input  logic               zero_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] result_out,
  output logic               overflow_out,
  output logic               underflow_out,
  output logic               inexact_out
);

  // Handshake: a beat moves across a boundary only on a cycle where valid and
  // ready are both high at the rising edge. Both stages shift together when
  // adv is high, so in_ready is just adv and depends only on the output side.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  s1_t  s1_d, s1_q;
  logic s1_valid;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign_in;
    s1_d.nan  = nan_in;
    s1_d.inf  = inf_in;
    s1_d.zero = zero_in;
    if (prod_in[P_WIDTH-1]) begin
      s1_d.mant   = prod_in[P_WIDTH-2 -: M_WIDTH];
      s1_d.rnd    = prod_in[P_WIDTH-M_WIDTH-2];
      s1_d.sticky = |prod_in[P_WIDTH-M_WIDTH-3:0];
      s1_d.exp    = exp_in + X_WIDTH'(1);
    end else begin
      s1_d.mant   = prod_in[P_WIDTH-3 -: M_WIDTH];
      s1_d.rnd    = prod_in[P_WIDTH-M_WIDTH-3];
      s1_d.sticky = |prod_in[P_WIDTH-M_WIDTH-4:0];
      s1_d.exp    = exp_in;
    end
  end

  logic [M_WIDTH-1:0] mant_r;
  logic               carry, rnd_inexact;

  rne_rounder #(.M_WIDTH(M_WIDTH)) u_rne_rounder (
    .mant    (s1_q.mant),
    .rnd     (s1_q.rnd),
    .sticky  (s1_q.sticky),
    .mant_r  (mant_r),
    .carry   (carry),
    .inexact (rnd_inexact)
  );

  logic [X_WIDTH-1:0] exp_r;
  logic [D_WIDTH-1:0] res_d;
  logic               ovf_d, unf_d, inx_d;

  assign exp_r = s1_q.exp + {{(X_WIDTH-1){1'b0}}, carry};

  // Specials win over arithmetic; range check is signed in the wide exponent.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (s1_q.nan) begin
      res_d = QNAN;
    end else if (s1_q.inf) begin
      res_d = {s1_q.sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, {(D_WIDTH-1){1'b0}}};
    end else if ($signed(exp_r) >= $signed(X_WIDTH'(EXP_MAX))) begin
      res_d = {s1_q.sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if ($signed(exp_r) <= $signed(X_WIDTH'(0))) begin
      res_d = {s1_q.sign, {(D_WIDTH-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, exp_r[E_WIDTH-1:0], mant_r};
      inx_d = rnd_inexact;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_q          <= '0;
      out_valid     <= 1'b0;
      result_out    <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      inexact_out   <= 1'b0;
    end else if (adv) begin
      s1_valid      <= in_valid;
      s1_q          <= s1_d;
      out_valid     <= s1_valid;
      result_out    <= res_d;
      overflow_out  <= ovf_d;
      underflow_out <= unf_d;
      inexact_out   <= inx_d;
    end
  end

endmodule
